// File: rtl/addsub_serial_pkg.sv
// Shared constants for the digit-serial adder/subtractor: operation codes and FSM encodings.
package addsub_serial_pkg;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StBusy = 2'd1;
   localparam logic [1:0] StDone = 2'd2;

endpackage

// File: rtl/addsub_digit.sv
// One digit slice of the serial adder: a DIGIT-bit ripple of full adders.
module addsub_digit
   import addsub_serial_pkg::*;
#(
   parameter int unsigned DIGIT = 2
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             cin,
   output logic [DIGIT-1:0] sum,
   output logic             cout,
   output logic             c_msb_in
);

   logic carry;

   always_comb begin
      carry    = cin;
      c_msb_in = cin;
      sum      = '0;
      for (int i = 0; i < int'(DIGIT); i++) begin
         // Carry entering the top bit feeds the signed-overflow flag.
         if (i == int'(DIGIT) - 1) c_msb_in = carry;
         sum[i] = a[i] ^ b[i] ^ carry;
         carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
      end
      cout = carry;
   end

endmodule

// File: rtl/addsub_serial.sv
// Digit-serial two's-complement adder/subtractor with valid/ready handshakes and C/V/Z flags.
module addsub_serial
   import addsub_serial_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DIGIT = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             c,
   output logic             v,
   output logic             z
);

   localparam int unsigned N  = WIDTH / DIGIT;
   localparam int unsigned CW = $clog2(N) + 1;

   if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_param
      $error("addsub_serial: illegal WIDTH/DIGIT combination");
   end

   logic [1:0]       state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic             op_q;
   logic             carry;
   logic [CW-1:0]    cnt;

   logic             accept;
   logic             last;
   logic [DIGIT-1:0] d_sum;
   logic             d_cout;
   logic             d_cmsb;
   logic [WIDTH-1:0] s_next;

   addsub_digit #(
      .DIGIT(DIGIT)
   ) u_digit (
      .a       (a_sh[DIGIT-1:0]),
      .b       (b_sh[DIGIT-1:0]),
      .cin     (carry),
      .sum     (d_sum),
      .cout    (d_cout),
      .c_msb_in(d_cmsb)
   );

   always_comb begin
      in_ready = (state == StIdle) || ((state == StDone) && out_ready);
      accept   = in_valid && in_ready;
      last     = (cnt == CW'(N - 1));
      // Result fills from the MSB end so the first digit lands at the bottom after N shifts.
      s_next   = WIDTH'({d_sum, s} >> DIGIT);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= StIdle;
         a_sh      <= '0;
         b_sh      <= '0;
         op_q      <= 1'b0;
         carry     <= 1'b0;
         cnt       <= '0;
         out_valid <= 1'b0;
         s         <= '0;
         c         <= 1'b0;
         v         <= 1'b0;
         z         <= 1'b0;
      end else if (accept) begin
         // Subtraction is A + ~B + 1: invert B here, the +1 rides in as the initial carry.
         a_sh      <= a;
         b_sh      <= b ^ {WIDTH{op == OP_SUB}};
         op_q      <= op;
         carry     <= (op == OP_SUB);
         cnt       <= '0;
         out_valid <= 1'b0;
         state     <= StBusy;
      end else begin
         case (state)
            StBusy: begin
               s     <= s_next;
               a_sh  <= a_sh >> DIGIT;
               b_sh  <= b_sh >> DIGIT;
               carry <= d_cout;
               cnt   <= cnt + 1'b1;
               if (last) begin
                  c         <= d_cout ^ op_q;
                  v         <= d_cmsb ^ d_cout;
                  z         <= (s_next == '0);
                  out_valid <= 1'b1;
                  state     <= StDone;
               end
            end
            StDone: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= StIdle;
               end
            end
            StIdle: ;
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_addsub_serial.sv
// Self-checking bench for addsub_serial at (8,2), (8,1), (8,8) and (16,4).
module tb_addsub_serial;

   localparam int NI   = 4;
   localparam int NOPS = 1500;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       op;
      int         stall;
      logic [7:0] s;
      logic       c;
      logic       v;
      logic       z;
   } vec_t;

   logic        clk;
   logic        rst;
   logic [15:0] a_i  [NI];
   logic [15:0] b_i  [NI];
   logic        op_i [NI];
   logic        iv   [NI];
   logic        ordy [NI];
   logic        ir   [NI];
   logic        ov   [NI];
   logic        c_o  [NI];
   logic        v_o  [NI];
   logic        z_o  [NI];
   logic [7:0]  s0, s1, s2;
   logic [15:0] s3;

   int wid  [NI] = '{8, 8, 8, 16};
   int ndig [NI] = '{4, 8, 1, 4};

   int n_checks = 0;
   int n_fail   = 0;

   addsub_serial #(.WIDTH(8), .DIGIT(2)) u0 (
      .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .a(a_i[0][7:0]),
      .b(b_i[0][7:0]), .op(op_i[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .s(s0),
      .c(c_o[0]), .v(v_o[0]), .z(z_o[0]));

   addsub_serial #(.WIDTH(8), .DIGIT(1)) u1 (
      .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .a(a_i[1][7:0]),
      .b(b_i[1][7:0]), .op(op_i[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .s(s1),
      .c(c_o[1]), .v(v_o[1]), .z(z_o[1]));

   addsub_serial #(.WIDTH(8), .DIGIT(8)) u2 (
      .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .a(a_i[2][7:0]),
      .b(b_i[2][7:0]), .op(op_i[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .s(s2),
      .c(c_o[2]), .v(v_o[2]), .z(z_o[2]));

   addsub_serial #(.WIDTH(16), .DIGIT(4)) u3 (
      .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir[3]), .a(a_i[3]),
      .b(b_i[3]), .op(op_i[3]), .out_valid(ov[3]), .out_ready(ordy[3]), .s(s3),
      .c(c_o[3]), .v(v_o[3]), .z(z_o[3]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: actual timeout required completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] rd_s(input int idx);
      case (idx)
         0:       return {8'h00, s0};
         1:       return {8'h00, s1};
         2:       return {8'h00, s2};
         default: return s3;
      endcase
   endfunction

   // Plain-integer reference: unsigned sum/difference for s and c, signed range test for v.
   function automatic void model(input int w, input logic [15:0] a, input logic [15:0] b,
                                 input logic op, output logic [15:0] s, output logic c,
                                 output logic v, output logic z);
      longint ua, ub, sa, sb, half, md, full, sr;
      ua   = longint'(a);
      ub   = longint'(b);
      half = longint'(1) << (w - 1);
      md   = half * 2;
      sa   = (ua >= half) ? ua - md : ua;
      sb   = (ub >= half) ? ub - md : ub;
      if (!op) begin
         full = ua + ub;
         sr   = sa + sb;
         c    = (full >= md);
      end else begin
         full = ua - ub;
         sr   = sa - sb;
         c    = (ua < ub);
      end
      s = 16'(full & (md - 1));
      v = (sr >= half) || (sr < -half);
      z = (s == 16'h0);
   endfunction

   // One complete transaction on instance idx, with an optional output stall.
   task automatic do_op(input int idx, input logic [15:0] a, input logic [15:0] b,
                        input logic op, input int stall, output logic [15:0] s,
                        output logic c, output logic v, output logic z);
      int w;
      int lat;
      @(negedge clk);
      a_i[idx]  = a;
      b_i[idx]  = b;
      op_i[idx] = op;
      iv[idx]   = 1'b1;
      ordy[idx] = 1'b0;
      w = 0;
      while (!ir[idx] && w < 16) begin
         @(negedge clk);
         w++;
      end
      check("in_ready_idle", 64'(ir[idx]), 64'd1);
      @(negedge clk);
      iv[idx]   = 1'b0;
      a_i[idx]  = 16'($urandom);
      b_i[idx]  = 16'($urandom);
      op_i[idx] = 1'($urandom);
      lat = 0;
      while (!ov[idx] && lat < 64) begin
         @(negedge clk);
         lat++;
      end
      check("latency", 64'(lat), 64'(ndig[idx]));
      s = rd_s(idx);
      c = c_o[idx];
      v = v_o[idx];
      z = z_o[idx];
      repeat (stall) begin
         @(negedge clk);
         check("stall_valid", 64'(ov[idx]), 64'd1);
         check("stall_in_ready", 64'(ir[idx]), 64'd0);
         check("stall_s", 64'(rd_s(idx)), 64'(s));
         check("stall_cvz", 64'({c_o[idx], v_o[idx], z_o[idx]}), 64'({c, v, z}));
      end
      ordy[idx] = 1'b1;
      @(negedge clk);
      ordy[idx] = 1'b0;
      check("valid_drop", 64'(ov[idx]), 64'd0);
   endtask

   initial begin
      vec_t        vecs[10];
      logic [15:0] rs, es, msk;
      logic        rc, rv, rz, ec, ev, ez, rop;
      logic [15:0] ra, rb;
      int          lat, st;
      logic [7:0]  pa[4], pb[4];
      logic        pop[4];

      vecs[0] = '{8'h7F, 8'h01, 1'b0, 0, 8'h80, 1'b0, 1'b1, 1'b0};
      vecs[1] = '{8'h00, 8'h01, 1'b1, 0, 8'hFF, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{8'h05, 8'h05, 1'b1, 0, 8'h00, 1'b0, 1'b0, 1'b1};
      vecs[3] = '{8'h80, 8'h01, 1'b1, 5, 8'h7F, 1'b0, 1'b1, 1'b0};
      vecs[4] = '{8'h10, 8'h20, 1'b0, 0, 8'h30, 1'b0, 1'b0, 1'b0};
      vecs[5] = '{8'hFF, 8'h01, 1'b0, 0, 8'h00, 1'b1, 1'b0, 1'b1};
      vecs[6] = '{8'h80, 8'h80, 1'b0, 2, 8'h00, 1'b1, 1'b1, 1'b1};
      vecs[7] = '{8'h7F, 8'hFF, 1'b1, 0, 8'h80, 1'b1, 1'b1, 1'b0};
      vecs[8] = '{8'h00, 8'h00, 1'b1, 0, 8'h00, 1'b0, 1'b0, 1'b1};
      vecs[9] = '{8'hC8, 8'h64, 1'b0, 0, 8'h2C, 1'b1, 1'b0, 1'b0};

      for (int i = 0; i < NI; i++) begin
         a_i[i]  = '0;
         b_i[i]  = '0;
         op_i[i] = 1'b0;
         iv[i]   = 1'b0;
         ordy[i] = 1'b0;
      end
      rst = 1'b1;

      // Reset state on every configuration.
      repeat (2) @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         check("rst_valid", 64'(ov[i]), 64'd0);
         check("rst_s", 64'(rd_s(i)), 64'd0);
         check("rst_cvz", 64'({c_o[i], v_o[i], z_o[i]}), 64'd0);
      end
      rst = 1'b0;
      #1;
      for (int i = 0; i < NI; i++) check("rst_in_ready", 64'(ir[i]), 64'd1);

      // Directed vectors with hand-computed results.
      for (int i = 0; i < 10; i++) begin
         do_op(0, {8'h00, vecs[i].a}, {8'h00, vecs[i].b}, vecs[i].op, vecs[i].stall,
               rs, rc, rv, rz);
         check($sformatf("vec%0d_s", i), 64'(rs), 64'(vecs[i].s));
         check($sformatf("vec%0d_c", i), 64'(rc), 64'(vecs[i].c));
         check($sformatf("vec%0d_v", i), 64'(rv), 64'(vecs[i].v));
         check($sformatf("vec%0d_z", i), 64'(rz), 64'(vecs[i].z));
      end

      // Back-to-back: in_valid held high, result consumed and next pair accepted together.
      pa  = '{8'h12, 8'h50, 8'hFF, 8'h7F};
      pb  = '{8'h34, 8'h60, 8'hFF, 8'h80};
      pop = '{1'b0, 1'b1, 1'b0, 1'b1};
      @(negedge clk);
      a_i[0]  = {8'h00, pa[0]};
      b_i[0]  = {8'h00, pb[0]};
      op_i[0] = pop[0];
      iv[0]   = 1'b1;
      ordy[0] = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("b2b_no_stale_valid", 64'(ov[0]), 64'd0);
         lat = 0;
         while (!ov[0] && lat < 64) begin
            @(negedge clk);
            lat++;
         end
         check("b2b_latency", 64'(lat), 64'd4);
         model(8, {8'h00, pa[k]}, {8'h00, pb[k]}, pop[k], es, ec, ev, ez);
         check("b2b_s", 64'(rd_s(0)), 64'(es));
         check("b2b_cvz", 64'({c_o[0], v_o[0], z_o[0]}), 64'({ec, ev, ez}));
         check("b2b_in_ready", 64'(ir[0]), 64'd1);
         if (k < 3) begin
            a_i[0]  = {8'h00, pa[k+1]};
            b_i[0]  = {8'h00, pb[k+1]};
            op_i[0] = pop[k+1];
         end else begin
            iv[0] = 1'b0;
         end
      end
      @(negedge clk);
      ordy[0] = 1'b0;
      check("b2b_final_drop", 64'(ov[0]), 64'd0);

      // Reset two cycles into BUSY discards the operation.
      @(negedge clk);
      a_i[0]  = 16'h0055;
      b_i[0]  = 16'h0022;
      op_i[0] = 1'b0;
      iv[0]   = 1'b1;
      @(negedge clk);
      iv[0] = 1'b0;
      repeat (2) @(negedge clk);
      #1 rst = 1'b1;
      #1;
      check("midrst_valid", 64'(ov[0]), 64'd0);
      check("midrst_s", 64'(rd_s(0)), 64'd0);
      check("midrst_cvz", 64'({c_o[0], v_o[0], z_o[0]}), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("midrst_in_ready", 64'(ir[0]), 64'd1);
      repeat (6) begin
         @(negedge clk);
         check("midrst_no_pulse", 64'(ov[0]), 64'd0);
      end
      do_op(0, 16'h0010, 16'h0020, 1'b0, 0, rs, rc, rv, rz);
      check("midrst_next_s", 64'(rs), 64'h30);

      // Randomised operations against the reference model on every configuration.
      for (int idx = 0; idx < NI; idx++) begin
         msk = (wid[idx] == 16) ? 16'hFFFF : 16'h00FF;
         repeat (NOPS) begin
            ra  = 16'($urandom) & msk;
            rb  = 16'($urandom) & msk;
            rop = 1'($urandom_range(0, 1));
            st  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 4)) : 0;
            do_op(idx, ra, rb, rop, st, rs, rc, rv, rz);
            model(wid[idx], ra, rb, rop, es, ec, ev, ez);
            check($sformatf("rnd%0d_s", idx), 64'(rs), 64'(es));
            check($sformatf("rnd%0d_c", idx), 64'(rc), 64'(ec));
            check($sformatf("rnd%0d_v", idx), 64'(rv), 64'(ev));
            check($sformatf("rnd%0d_z", idx), 64'(rz), 64'(ez));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
